// File: rtl/dir_rom_scanner.sv
// dir_rom_scanner
//   Walks the 16x16 orientation-offset ROM in raster order (addr = {row,col})
//   and streams each captured offset downstream over valid/ready. Each sample
//   is tagged with its row/col and a flag for offsets outside [WIN_LO, WIN_HI].
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle scan request (ignored while busy or during done)
//   busy            scan in progress (cycle after accepted start .. done)
//   done            one-cycle pulse after the last sample is accepted
//   rom_addr        ROM address, always equal to the index counter
//   rom_data        combinational ROM read data for rom_addr
//   out_valid/ready downstream handshake
//   out_row/col     sample position
//   out_off         captured signed offset
//   out_oob         offset outside the window (signed compare)
module dir_rom_scanner #(
  parameter int DW     = 5,
  parameter int WIN_LO = -8,
  parameter int WIN_HI = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [7:0]    rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_row,
  output logic [3:0]    out_col,
  output logic [DW-1:0] out_off,
  output logic          out_oob
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_LAST = 2'd2;

  localparam logic signed [DW-1:0] LO = WIN_LO[DW-1:0];
  localparam logic signed [DW-1:0] HI = WIN_HI[DW-1:0];

  logic [1:0] state;
  logic [7:0] idx;
  logic       load;
  logic       oob_n;
  logic signed [DW-1:0] rd_s;

  assign rom_addr = idx;
  // Output register is free or being drained this cycle.
  assign load  = !out_valid || out_ready;
  assign rd_s  = rom_data;
  assign oob_n = (rd_s < LO) || (rd_s > HI);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= 8'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_row   <= 4'd0;
      out_col   <= 4'd0;
      out_off   <= '0;
      out_oob   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // done is still high in the first IDLE cycle; a start there is dropped.
          if (start && !done) begin
            idx   <= 8'd0;
            busy  <= 1'b1;
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (load) begin
            out_off   <= rom_data;
            out_row   <= idx[7:4];
            out_col   <= idx[3:0];
            out_oob   <= oob_n;
            out_valid <= 1'b1;
            // Park on 255 rather than wrapping; LAST only drains sample 255.
            if (idx == 8'hff) state <= S_LAST;
            else              idx   <= idx + 8'd1;
          end
        end
        S_LAST: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            busy      <= 1'b0;
            idx       <= 8'd0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dir_rom_scanner.sv
module tb_dir_rom_scanner;
  localparam int DW = 5;

  logic          clk = 1'b0;
  logic          rst, start, out_ready;
  logic          busy, done, out_valid, out_oob;
  logic [7:0]    rom_addr;
  logic [DW-1:0] rom_data, out_off;
  logic [3:0]    out_row, out_col;

  logic [DW-1:0] rom [256];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  dir_rom_scanner #(.DW(DW), .WIN_LO(-8), .WIN_HI(7)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_col(out_col), .out_off(out_off), .out_oob(out_oob)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: two's-complement value of a DW-bit entry, and the window rule.
  function automatic int sval(input logic [DW-1:0] v);
    int u;
    u = int'(v);
    return (u >= 2**(DW-1)) ? u - 2**DW : u;
  endfunction

  function automatic logic exp_oob(input int i);
    int s;
    s = sval(rom[i]);
    return (s < -8) || (s > 7);
  endfunction

  task automatic chk_sample(input string tag, input int i);
    chk({tag, "_row"}, 32'(out_row), 32'(i / 16));
    chk({tag, "_col"}, 32'(out_col), 32'(i % 16));
    chk({tag, "_off"}, 32'(out_off), 32'(rom[i]));
    chk({tag, "_oob"}, 32'(out_oob), 32'(exp_oob(i)));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_addr"}, 32'(rom_addr), 0);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_row"}, 32'(out_row), 0);
    chk({tag, "_col"}, 32'(out_col), 0);
    chk({tag, "_off"}, 32'(out_off), 0);
    chk({tag, "_oob"}, 32'(out_oob), 0);
  endtask

  // One scan, stepped at negedges. Returns at the negedge of the done cycle
  // (optionally leaving start high there) or right after an abort.
  task automatic run_scan(input int ready_pct, input bit extra_start,
                          input bit stall_last, input int abort_at);
    int ntx = 0;
    int cyc = 0;
    int stall_cnt = 0;
    bit fin = 0;
    logic pv = 0, pr = 0, hb = 0;
    logic [3:0] hr = 0, hc = 0;
    logic [DW-1:0] ho = 0;

    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);
    start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", 32'(busy), 1);
    chk("start_addr", 32'(rom_addr), 0);
    chk("lat1_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat2_valid", 32'(out_valid), 1);

    while (!fin && cyc < 4000) begin
      start = 1'b0;
      if (pv && !pr) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_row", 32'(out_row), 32'(hr));
        chk("hold_col", 32'(out_col), 32'(hc));
        chk("hold_off", 32'(out_off), 32'(ho));
        chk("hold_oob", 32'(out_oob), 32'(hb));
      end
      if (ntx == 256) begin
        chk("done_pulse", 32'(done), 1);
        chk("done_busy", 32'(busy), 0);
        chk("done_valid", 32'(out_valid), 0);
        if (ready_pct == 100 && !stall_last) chk("thru_cycles", 32'(cyc), 256);
        if (extra_start) start = 1'b1;
        fin = 1;
      end else begin
        chk("no_early_done", 32'(done), 0);
        if (abort_at >= 0 && ntx == abort_at && out_valid) begin
          out_ready = 1'b0;
          @(negedge clk);
          @(negedge clk);
          @(posedge clk);
          #2 rst = 1'b1;
          #1 chk_reset_outs("abort");
          @(negedge clk);
          rst = 1'b0;
          repeat (4) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
            chk("abort_idle", 32'(busy), 0);
          end
          return;
        end
        if (extra_start && ntx == 100) start = 1'b1;
        if (stall_last && ntx == 255 && out_valid && stall_cnt < 10) begin
          out_ready = 1'b0;
          stall_cnt++;
          chk_sample("last_hold", 255);
          chk("last_addr", 32'(rom_addr), 255);
        end else begin
          out_ready = ($urandom_range(99) < ready_pct);
        end
        if (out_valid && out_ready) begin
          chk_sample("xfer", ntx);
          ntx++;
        end
        pv = out_valid; pr = out_ready;
        hr = out_row; hc = out_col; ho = out_off; hb = out_oob;
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("scan_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = DW'($urandom);
    rom[0]   = 5'h01;
    rom[16]  = 5'h00;
    rom[32]  = 5'h1f;
    rom[15]  = 5'h0b;
    rom[240] = 5'h15;
    rom[255] = 5'h1f;

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    #1 chk_reset_outs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_scan(100, 1'b0, 1'b0, -1);  // full-rate scan
    run_scan(50,  1'b1, 1'b0, -1);  // random stalls, starts while busy and at done
    run_scan(100, 1'b0, 1'b1, -1);  // start right after done, stall on last sample
    run_scan(50,  1'b0, 1'b0, 77);  // asynchronous reset mid-stall
    run_scan(70,  1'b0, 1'b0, -1);  // restart after abort

    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dir_rom_scanner.md
Name: dir_rom_scanner

Overview:
- Initiator/reader for the 16x16 orientation-offset distributed ROMs (256 x 5-bit signed entries, combinational read, address = {row[3:0], col[3:0]}).
- On start, it walks the full descriptor sample window in raster order and drives the ROM address. It captures each returned offset and presents it downstream with valid/ready backpressure, tagged with row/col and an out-of-window flag.
- Sits between the keypoint orientation stage and the descriptor histogram accumulator.

Parameters:
- DW, 5, ROM data width (two's-complement signed offset).
- WIN_LO, -8, lowest in-window offset (signed, DW bits).
- WIN_HI, 7, highest in-window offset (signed, DW bits).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request to begin a 256-sample scan; ignored while busy=1.
- busy  output  1  high from the cycle after an accepted start until done is asserted.
- done  output  1  one-cycle pulse after the last sample has been accepted downstream.
- rom_addr  output  8  ROM address {row, col}.
- rom_data  input  DW  ROM read data, valid combinationally in the same cycle as rom_addr.
- out_valid  output  1  output sample valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- out_row  output  4  row of the sample.
- out_col  output  4  column of the sample.
- out_off  output  DW  captured signed offset.
- out_oob  output  1  1 when out_off < WIN_LO or out_off > WIN_HI (signed compare).

Behaviour:
- Reset values: busy=0, done=0, rom_addr=0, out_valid=0, out_row=0, out_col=0, out_off=0, out_oob=0. State goes to IDLE and the index counter to 0.
- The reset is asynchronous and can occur mid-scan. It aborts the scan immediately, and no done pulse is produced.
- There is one 8-bit index counter idx. rom_addr = idx at all times (registered counter, not recomputed combinationally from the handshake).
- States:
  - IDLE: on start, set idx=0 and go to SCAN; busy rises the next cycle.
  - SCAN: load condition is load = !out_valid || out_ready.
    - On load: out_off<=rom_data, out_row<=idx[7:4], out_col<=idx[3:0], out_oob<=compare(rom_data), out_valid<=1.
    - If idx==255 on load, go to LAST. Otherwise idx<=idx+1.
    - Without load: hold all registers and idx.
  - LAST: idx stays at 255 (no wrap to 0 inside a scan).
    - When out_valid && out_ready: out_valid<=0, done<=1 for one cycle, busy<=0, idx<=0, go to IDLE.
- Latency: the first sample is valid 2 cycles after the start cycle (one cycle to enter SCAN, one to load).
- Throughput: 1 sample/cycle with out_ready held high. A full scan takes 256 load cycles plus 1 drain cycle.
- Backpressure: out_* are stable while out_valid && !out_ready. Exactly 256 transfers occur per scan, in raster order, with no duplicates or skips.
- start while busy=1, or in the same cycle as done, is ignored. start in the cycle after done is accepted.
- Arithmetic: out_oob compares signed DW-bit values, so rom_data 5'h1f is -1, not 31.

Test Plan:
- Reset, start pulse, out_ready=1 → first transfer at start+2: row=0, col=0, off=5'h01, oob=0. Transfer 16: row=1, col=0, off=5'h00. Transfer 32: row=2, col=0, off=5'h1f (-1), oob=0.
- Full scan with out_ready=1 → exactly 256 transfers. Addr 15 gives off=5'h0b, oob=1 (11>7). Addr 240 gives off=5'h15, oob=1 (-11<-8). Addr 255 gives off=5'h1f, oob=0. done pulses once, 1 cycle after the last transfer. busy=0 afterwards.
- out_ready random (~50%) → the transfer sequence matches the row/col/off sequence of the ready=1 run. out_* are held stable every stalled cycle.
- start re-asserted at sample 100 and again in the done cycle → both ignored, still 256 transfers. A start one cycle after done begins a new scan from addr 0.
- rst asserted asynchronously at sample 77 (mid-stall) → outputs immediately go to their reset values and there is no done. A new start restarts from addr 0.
- out_ready=0 at the last sample for 10 cycles → LAST holds row=15, col=15, off=5'h1f. done asserts only after the accepting cycle.
